mem_req_arbiter: RTL
====================

Name: mem_req_arbiter

Overview:
- Sequences and shares the single-port parity memory (my_mem: clk, write, read, data_in[7:0], address[15:0], data_out[8:0] = {^data, data}) among NUM_REQ requesters.
- Round-robin arbitration with a req/ack handshake per requester.
- Drives one write or read strobe per granted transaction.
- Captures read data and checks its stored parity bit.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_W, 16, memory address width.
- DATA_W, 8, memory data width, excluding the parity bit.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  per-requester request; held high until its ack.
- req_we  input  NUM_REQ  per-requester op: 1 = write, 0 = read.
- req_addr  input  NUM_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W].
- req_wdata  input  NUM_REQ*DATA_W  packed write data, same packing.
- ack  output  NUM_REQ  one-cycle completion pulse to the granted requester.
- rdata  output  DATA_W  read data; valid when ack pulses for a read.
- rdata_perr  output  1  parity mismatch on the returned read; valid with ack.
- busy  output  1  high in every state except IDLE.
- grant_id  output  $clog2(NUM_REQ)  index of the current or last winner.
- mem_write  output  1  memory write strobe.
- mem_read  output  1  memory read strobe.
- mem_data_in  output  DATA_W  memory write data.
- mem_address  output  ADDR_W  memory address.
- mem_data_out  input  DATA_W+1  memory read data {parity, data}; valid the cycle after mem_read.

Behaviour:
- Reset values (synchronous, next posedge with reset=1):
  - state=IDLE; ack=0; rdata=0; rdata_perr=0; busy=0; grant_id=0.
  - mem_write=0, mem_read=0, mem_data_in=0, mem_address=0.
  - rr pointer=0.
- IDLE:
  - If req!=0, select the winner round-robin: first set bit at or after the pointer, wrapping modulo NUM_REQ.
  - Register grant_id, op, address and wdata from the winner, then go to ACCESS.
  - If req==0, stay in IDLE.
- ACCESS (exactly 1 cycle):
  - mem_address and mem_data_in drive the registered values.
  - mem_write=op, mem_read=~op; never both high.
  - Write goes to DONE; read goes to CAPTURE.
- CAPTURE (read only, 1 cycle):
  - rdata <= mem_data_out[DATA_W-1:0].
  - rdata_perr <= mem_data_out[DATA_W] != ^mem_data_out[DATA_W-1:0].
  - Go to DONE.
- DONE (1 cycle):
  - ack[grant_id]=1; all other ack bits 0.
  - pointer <= (grant_id+1) mod NUM_REQ.
  - Go to IDLE.
- Latency from req sampled in IDLE to ack high: write 2 cycles, read 3 cycles.
- Throughput: one transaction per 3 (write) or 4 (read) cycles.
- Strobes are 0 outside ACCESS; mem_address and mem_data_in hold their last values.
- rdata and rdata_perr hold until the next read capture.
- A write ack leaves rdata and rdata_perr unchanged.
- Requesters must not raise a new req in the cycle their ack is high.
- The granted requester is not re-sampled: if it deasserts req before ack, the transaction still completes and ack still pulses.
- Non-granted requesters may change req freely; arbitration happens only in IDLE.
- Simultaneous requests: exactly one grant per IDLE cycle. Fairness bound: a held request is granted within NUM_REQ transactions.
- reset in any state overrides everything and returns to IDLE next cycle:
  - No ack is issued for the aborted transaction.
  - Strobes drop immediately.
  - The pointer returns to 0.

Decomposition:
- Package mem_arb_pkg:
  - typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, DONE} arb_state_t.
  - typedef enum logic {OP_READ, OP_WRITE} mem_op_t.
  - Parity helper function.
- Sub-module rr_arbiter:
  - Combinational round-robin priority select.
  - Inputs: req[NUM_REQ], pointer.
  - Outputs: one-hot grant, encoded index, any_req.

Test Plan:
- Single write then read: req0 writes addr 16'h1234 data 8'hA5; req0 reads 16'h1234 -> write ack 2 cycles after sample, read ack 3 cycles after, rdata=8'hA5, rdata_perr=0, mem_read/mem_write each high exactly 1 cycle.
- All-requester contention: req=4'b1111 all writes held from reset release -> acks in order 0,1,2,3,0; grant_id follows; never two ack bits high.
- Pointer wrap: pointer=3 after granting req2, req=4'b0011 -> req0 wins, then req1.
- Parity error: force mem_data_out=9'h0FF (bit8=0, ^8'hFF=0), then 9'h1FF -> rdata_perr=0 then 1, rdata=8'hFF in both cases.
- Reset mid-read: assert reset during CAPTURE -> no ack, busy=0 and strobes 0 next cycle, next grant starts from req0.
- Early req drop: req1 read drops req after 1 cycle -> ack[1] still pulses 3 cycles after sample, no other transaction starts before DONE.

Source files
------------

// File: rtl/mem_req_arbiter_pkg.sv
// Shared types and helpers for the parity-memory request arbiter.
// Holds FSM state and memory-op encodings plus the parity function.
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, DONE} arb_state_t;

  typedef enum logic {OP_READ, OP_WRITE} mem_op_t;

  localparam int PARITY_MAX_W = 64;

  // Zero-extending a narrower word leaves its XOR parity unchanged.
  function automatic logic xor_parity(input logic [PARITY_MAX_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/mem_req_arbiter_rr_arbiter.sv
// Combinational round-robin select: the first requester at or after
// the pointer wins, wrapping modulo NUM_REQ.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] pointer,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx,
  output logic                       any_req
);

  localparam int IDX_W = $clog2(NUM_REQ);

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_req   = 1'b0;
    // Offset 0 is the pointer itself; positions past the top wrap to 0.
    for (int off = 0; off < NUM_REQ; off++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!any_req && req[j] &&
            ((int'(pointer) + off == j) || (int'(pointer) + off == j + NUM_REQ))) begin
          any_req   = 1'b1;
          grant[j]  = 1'b1;
          grant_idx = IDX_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Shares one single-port parity memory among NUM_REQ requesters with
// round-robin arbitration, one strobe per transaction and read parity check.
module mem_req_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ-1:0]          req_we,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]          ack,
  output logic [DATA_W-1:0]           rdata,
  output logic                        rdata_perr,
  output logic                        busy,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        mem_write,
  output logic                        mem_read,
  output logic [DATA_W-1:0]           mem_data_in,
  output logic [ADDR_W-1:0]           mem_address,
  input  logic [DATA_W:0]             mem_data_out
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_t         state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_next;
  logic [IDX_W-1:0]   grant_id_q;

  logic [NUM_REQ-1:0] win_grant;
  logic [IDX_W-1:0]   win_idx;
  logic               any_req;

  logic               sel_we;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;

  mem_op_t            op_p0;
  logic [ADDR_W-1:0]  addr_p0;
  logic [DATA_W-1:0]  wdata_p0;

  logic [DATA_W-1:0]  rdata_p1;
  logic               perr_p1;
  logic [DATA_W-1:0]  cap_data;
  logic               cap_perr;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .req       (req),
    .pointer   (ptr_q),
    .grant     (win_grant),
    .grant_idx (win_idx),
    .any_req   (any_req)
  );

  // One-hot mux of the winner's operation fields.
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_grant[i]) begin
        sel_we    = req_we[i];
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign cap_data = mem_data_out[DATA_W-1:0];
  assign cap_perr = mem_data_out[DATA_W] ^ xor_parity(PARITY_MAX_W'(cap_data));

  assign ptr_next = (grant_id_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_id_q + IDX_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      grant_id_q <= '0;
      op_p0      <= OP_READ;
      addr_p0    <= '0;
      wdata_p0   <= '0;
      rdata_p1   <= '0;
      perr_p1    <= 1'b0;
    end else begin
      state_q <= state_d;
      // Stage p0: the winner's request is latched; the requester is not re-sampled.
      if (state_q == IDLE && any_req) begin
        grant_id_q <= win_idx;
        op_p0      <= sel_we ? OP_WRITE : OP_READ;
        addr_p0    <= sel_addr;
        wdata_p0   <= sel_wdata;
      end
      // Stage p1: memory returns read data the cycle after the read strobe.
      if (state_q == CAPTURE) begin
        rdata_p1 <= cap_data;
        perr_p1  <= cap_perr;
      end
      if (state_q == DONE) begin
        ptr_q <= ptr_next;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ack       = '0;
    mem_write = 1'b0;
    mem_read  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any_req) state_d = ACCESS;
      end
      ACCESS: begin
        mem_write = (op_p0 == OP_WRITE);
        mem_read  = (op_p0 == OP_READ);
        state_d   = (op_p0 == OP_WRITE) ? DONE : CAPTURE;
      end
      CAPTURE: begin
        state_d = DONE;
      end
      DONE: begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (grant_id_q == IDX_W'(i)) ack[i] = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy        = (state_q != IDLE);
  assign grant_id    = grant_id_q;
  assign mem_address = addr_p0;
  assign mem_data_in = wdata_p0;
  assign rdata       = rdata_p1;
  assign rdata_perr  = perr_p1;

endmodule
